// File: rtl/ysyx_25020037_scoreboard.sv
// Issue-side GPR scoreboard: tracks in-flight register writes from issue to
// writeback, stalls on RAW hazards and in-flight limits, and serialises
// ecall/mret/csr instructions behind an empty pipeline.
module ysyx_25020037_scoreboard #(
  parameter int unsigned NREG  = 16,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TOT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_rd,
  input  logic             issue_we,
  input  logic [3:0]       issue_rs1,
  input  logic             issue_rs1_en,
  input  logic [3:0]       issue_rs2,
  input  logic             issue_rs2_en,
  input  logic             issue_serial,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  input  logic             wb_we,
  input  logic             flush,
  output logic [NREG-1:0]  busy_vec,
  output logic [TOT_W-1:0] inflight,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_LIM = TOT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             ser_pend_q, ser_pend_d;
  logic             err_q, err_d;

  logic raw, full, fire;
  logic inc_en, commit_en, same_reg, inc_ok, dec_ok, ovf, underflow;

  // Hazard, limit and handshake decode from registered counters only.
  always_comb begin
    raw  = (issue_rs1_en && issue_rs1 != 4'd0 && cnt_q[issue_rs1] != '0) ||
           (issue_rs2_en && issue_rs2 != 4'd0 && cnt_q[issue_rs2] != '0);
    full = (issue_we && issue_rd != 4'd0) &&
           (cnt_q[issue_rd] == CNT_MAX || tot_q == TOT_LIM);
    issue_ready = !rst && state_q == S_RUN && !flush && !raw && !full &&
                  (!issue_serial || tot_q == '0);
    fire = issue_valid && issue_ready;

    inc_en    = fire && issue_we && issue_rd != 4'd0;
    commit_en = wb_valid && wb_we && wb_rd != 4'd0 && !flush && state_q != S_FLUSH;
    same_reg  = inc_en && commit_en && issue_rd == wb_rd;
    // A same-register fire+commit nets to zero, so neither limit can trip.
    ovf       = inc_en && !same_reg && cnt_q[issue_rd] == CNT_MAX;
    underflow = commit_en && !same_reg && cnt_q[wb_rd] == '0;
    inc_ok    = inc_en && !ovf;
    dec_ok    = commit_en && !underflow;
  end

  // Next-state: counters, serial tracking, FSM and sticky error.
  always_comb begin
    state_d    = state_q;
    ser_pend_d = ser_pend_q;
    err_d      = err_q || ovf || underflow;
    tot_d      = tot_q + TOT_W'(inc_ok) - TOT_W'(dec_ok);
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i]
               + CNT_W'(inc_ok && issue_rd == 4'(i))
               - CNT_W'(dec_ok && wb_rd == 4'(i));
    end

    case (state_q)
      S_RUN: begin
        if (fire && issue_serial) begin
          state_d    = S_DRAIN;
          ser_pend_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Pipeline was empty at serial issue, so the first commit is it.
        if (wb_valid && ser_pend_q) begin
          state_d    = S_RUN;
          ser_pend_d = 1'b0;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (flush) begin
      state_d    = S_FLUSH;
      ser_pend_d = 1'b0;
      tot_d      = '0;
      for (int i = 0; i < NREG; i++) cnt_d[i] = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      tot_q      <= '0;
      ser_pend_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      tot_q      <= tot_d;
      ser_pend_q <= ser_pend_d;
      err_q      <= err_d;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Status outputs derived directly from registered counters.
  always_comb begin
    for (int i = 0; i < NREG; i++) busy_vec[i] = cnt_q[i] != '0;
    inflight = tot_q;
    sb_err   = err_q;
  end

endmodule

// File: tb/tb_ysyx_25020037_scoreboard.sv
// Directed bench for the issue-side scoreboard.
module tb_ysyx_25020037_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_we, issue_rs1_en, issue_rs2_en, issue_serial;
  logic [3:0]  issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic        wb_valid, wb_we, flush;
  logic [15:0] busy_vec;
  logic [2:0]  inflight;
  logic        sb_err;

  int errors = 0;
  int checks = 0;

  ysyx_25020037_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_rs1(issue_rs1), .issue_rs1_en(issue_rs1_en),
    .issue_rs2(issue_rs2), .issue_rs2_en(issue_rs2_en),
    .issue_serial(issue_serial),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .flush(flush), .busy_vec(busy_vec), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic v, input logic [3:0] rd, input logic we,
                     input logic [3:0] rs1, input logic e1, input logic ser);
    issue_valid = v; issue_rd = rd; issue_we = we;
    issue_rs1 = rs1; issue_rs1_en = e1;
    issue_rs2 = 4'd0; issue_rs2_en = 1'b0; issue_serial = ser;
    #1;
  endtask

  task automatic wb(input logic v, input logic [3:0] rd, input logic we);
    wb_valid = v; wb_rd = rd; wb_we = we;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    iss(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
    wb(1'b0, 4'd0, 1'b0);
    tick(); tick();
    chk("ready_in_rst", 32'(issue_ready), 32'd0);
    rst = 1'b0; #1;
    chk("rst_busy", 32'(busy_vec), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);

    // 1: RAW on x5 until the cycle after its commit
    chk("t1_ready_rd5", 32'(issue_ready), 32'd1);
    tick();
    iss(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
    chk("t1_raw_stall", 32'(issue_ready), 32'd0);
    chk("t1_busy5", 32'(busy_vec), 32'h0020);
    chk("t1_inflight", 32'(inflight), 32'd1);
    tick();
    wb(1'b1, 4'd5, 1'b1);
    chk("t1_stall_commit_cycle", 32'(issue_ready), 32'd0);
    tick();
    wb(1'b0, 4'd0, 1'b0);
    chk("t1_ready_after", 32'(issue_ready), 32'd1);
    chk("t1_busy_clear", 32'(busy_vec), 32'h0);
    chk("t1_inflight0", 32'(inflight), 32'd0);
    tick();

    // 2: x0 never tracked
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    iss(1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("t2_no_stall", 32'(issue_ready), 32'd1);
    chk("t2_busy", 32'(busy_vec), 32'h0);
    chk("t2_inflight", 32'(inflight), 32'd0);
    tick();

    // 3a: per-register limit on x3
    iss(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    chk("t3_cnt_full", 32'(issue_ready), 32'd0);
    chk("t3_inflight3", 32'(inflight), 32'd3);
    chk("t3_busy3", 32'(busy_vec), 32'h0008);
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b1, 4'd3, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    wb(1'b0, 4'd0, 1'b0);
    chk("t3_drained", 32'(inflight), 32'd0);

    // 3b: global depth limit
    for (int r = 1; r <= 4; r++) begin
      iss(1'b1, 4'(r), 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
    end
    iss(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("t3_tot_full", 32'(issue_ready), 32'd0);
    chk("t3_inflight4", 32'(inflight), 32'd4);
    chk("t3_busy1to4", 32'(busy_vec), 32'h001e);
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int r = 1; r <= 4; r++) begin
      wb(1'b1, 4'(r), 1'b1);
      tick();
    end
    wb(1'b0, 4'd0, 1'b0);
    chk("t3b_drained", 32'(inflight), 32'd0);

    // 4: same-cycle fire and commit on x7
    iss(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    wb(1'b1, 4'd7, 1'b1);
    chk("t4_ready", 32'(issue_ready), 32'd1);
    tick();
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b0, 4'd0, 1'b0);
    chk("t4_inflight", 32'(inflight), 32'd1);
    chk("t4_busy7", 32'(busy_vec), 32'h0080);
    wb(1'b1, 4'd7, 1'b1);
    tick();
    wb(1'b0, 4'd0, 1'b0);

    // 5: serial instruction waits for empty pipeline, then drains
    iss(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    iss(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    iss(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("t5_ser_wait", 32'(issue_ready), 32'd0);
    chk("t5_inflight2", 32'(inflight), 32'd2);
    wb(1'b1, 4'd1, 1'b1); tick();
    chk("t5_ser_wait1", 32'(issue_ready), 32'd0);
    wb(1'b1, 4'd2, 1'b1); tick();
    wb(1'b0, 4'd0, 1'b0);
    chk("t5_ser_ready", 32'(issue_ready), 32'd1);
    tick();
    iss(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("t5_drain_block", 32'(issue_ready), 32'd0);
    chk("t5_ser_counted", 32'(inflight), 32'd1);
    tick();
    wb(1'b1, 4'd4, 1'b1);
    chk("t5_drain_commit_cycle", 32'(issue_ready), 32'd0);
    tick();
    wb(1'b0, 4'd0, 1'b0);
    chk("t5_run_again", 32'(issue_ready), 32'd1);
    chk("t5_inflight0", 32'(inflight), 32'd0);
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

    // 6: underflow sets sticky error; flush clears tracking
    wb(1'b1, 4'd9, 1'b1); tick();
    wb(1'b0, 4'd0, 1'b0);
    chk("t6_err_set", 32'(sb_err), 32'd1);
    chk("t6_no_underflow", 32'(inflight), 32'd0);
    for (int r = 1; r <= 3; r++) begin
      iss(1'b1, 4'(r), 1'b1, 4'd0, 1'b0, 1'b0);
      tick();
    end
    chk("t6_inflight3", 32'(inflight), 32'd3);
    iss(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 1'b0);
    flush = 1'b1;
    wb(1'b1, 4'd1, 1'b1);
    chk("t6_flush_block", 32'(issue_ready), 32'd0);
    tick();
    flush = 1'b0;
    wb(1'b0, 4'd0, 1'b0);
    chk("t6_flush_inflight", 32'(inflight), 32'd0);
    chk("t6_flush_busy", 32'(busy_vec), 32'h0);
    chk("t6_flush_state", 32'(issue_ready), 32'd0);
    tick();
    chk("t6_after_flush", 32'(issue_ready), 32'd1);
    chk("t6_err_held", 32'(sb_err), 32'd1);
    iss(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("t6_err_cleared", 32'(sb_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
